// File: rtl/sram_dbus_scheduler_pkg.sv
// Shared encodings for the SRAM data-bus scheduler: grant codes and FSM states.
// The DBus/VGA debug taps import this package as well.
package sram_dbus_scheduler_pkg;

  localparam logic [1:0] GNT_IDLE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_G0   = 2'd1,
    ST_G1   = 2'd2
  } state_t;

  function automatic logic [1:0] state_grant(state_t s);
    case (s)
      ST_G0:   state_grant = GNT_M0;
      ST_G1:   state_grant = GNT_M1;
      default: state_grant = GNT_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/sram_dbus_scheduler_sched_pick.sv
// Combinational winner select between M0 (pick=0) and M1 (pick=1):
// VGA urgency, then CPU starvation override, then round-robin against last.
module sched_pick (
  input  logic [1:0] stb,
  input  logic       urgent,
  input  logic       starve,
  input  logic       last,
  output logic       pick
);

  always_comb begin
    pick = 1'b0;
    if (stb[1] && urgent) begin
      pick = 1'b1;
    end else if (stb[0] && starve) begin
      pick = 1'b0;
    end else if (stb[0] && stb[1]) begin
      pick = ~last;
    end else begin
      pick = stb[1];
    end
  end

endmodule

// File: rtl/sram_dbus_scheduler.sv
// Two-master SRAM scheduler: CPU data bus (M0) and VGA fetcher (M1) share one
// nak-handshake slave; a grant is held for a whole transaction, bursts are bounded.
import sram_dbus_scheduler_pkg::*;

module sram_dbus_scheduler #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int BURST_MAX  = 4,
  parameter int STARVE_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_stb,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [3:0]        m0_dm,
  input  logic [DATA_W-1:0] m0_dout,
  output logic [DATA_W-1:0] m0_din,
  output logic              m0_nak,
  input  logic              m1_stb,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [3:0]        m1_dm,
  input  logic [DATA_W-1:0] m1_dout,
  output logic [DATA_W-1:0] m1_din,
  output logic              m1_nak,
  input  logic              m1_urgent,
  output logic              s_stb,
  output logic [ADDR_W-1:0] s_addr,
  output logic [3:0]        s_dm,
  output logic [DATA_W-1:0] s_din,
  input  logic [DATA_W-1:0] s_dout,
  input  logic              s_nak,
  output logic [1:0]        grant,
  output logic              starve
);

  localparam int BURST_W = $clog2(BURST_MAX + 1);
  localparam int WAIT_W  = $clog2(STARVE_MAX + 1);

  state_t               state_reg, state_next;
  logic                 last_reg, last_next;
  logic [BURST_W-1:0]   burst_cnt_reg, burst_cnt_next;
  logic [WAIT_W-1:0]    wait_cnt_reg, wait_cnt_next;

  logic [1:0] stb_vec;
  logic       granted, owner, owner_stb, complete;
  logic       idle_pick, cont_pick, burst_more;

  assign stb_vec    = {m1_stb, m0_stb};
  assign granted    = (state_reg != ST_IDLE);
  assign owner      = (state_reg == ST_G1);
  assign owner_stb  = owner ? m1_stb : m0_stb;
  assign s_stb      = granted & owner_stb;
  assign complete   = s_stb & ~s_nak;
  assign starve     = (wait_cnt_reg == WAIT_W'(STARVE_MAX));
  assign grant      = state_grant(state_reg);
  assign burst_more = (burst_cnt_reg < BURST_W'(BURST_MAX - 1));

  sched_pick u_pick_idle (
    .stb    (stb_vec),
    .urgent (m1_urgent),
    .starve (starve),
    .last   (last_reg),
    .pick   (idle_pick)
  );

  // Continuation check: would the owner still win if it had just become "last"?
  sched_pick u_pick_cont (
    .stb    (stb_vec),
    .urgent (m1_urgent),
    .starve (starve),
    .last   (owner),
    .pick   (cont_pick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      last_reg      <= 1'b1;
      burst_cnt_reg <= '0;
      wait_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      last_reg      <= last_next;
      burst_cnt_reg <= burst_cnt_next;
      wait_cnt_reg  <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    last_next      = last_reg;
    burst_cnt_next = burst_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        burst_cnt_next = '0;
        if (|stb_vec) state_next = idle_pick ? ST_G1 : ST_G0;
      end
      ST_G0, ST_G1: begin
        if (!owner_stb) begin
          state_next     = ST_IDLE;
          burst_cnt_next = '0;
        end else if (complete) begin
          last_next = owner;
          if (burst_more && (cont_pick == owner) && !(owner && starve)) begin
            burst_cnt_next = burst_cnt_reg + BURST_W'(1);
          end else begin
            state_next     = ST_IDLE;
            burst_cnt_next = '0;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if ((state_reg == ST_G0) && complete) begin
      wait_cnt_next = '0;
    end else if (m0_stb && (state_reg != ST_G0) && !starve) begin
      wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
    end
  end

  // The non-granted master always sees a stall and zero read data.
  always_comb begin
    m0_nak = 1'b1;
    m1_nak = 1'b1;
    m0_din = '0;
    m1_din = '0;
    s_addr = '0;
    s_dm   = '0;
    s_din  = '0;
    case (state_reg)
      ST_G0: begin
        m0_nak = s_nak;
        m0_din = s_dout;
        s_addr = m0_addr;
        s_dm   = m0_dm;
        s_din  = m0_dout;
      end
      ST_G1: begin
        m1_nak = s_nak;
        m1_din = s_dout;
        s_addr = m1_addr;
        s_dm   = m1_dm;
        s_din  = m1_dout;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_dbus_scheduler.sv
// Directed bench for sram_dbus_scheduler: inputs driven 1 time unit after the
// rising edge, outputs sampled on the falling edge.
module tb_sram_dbus_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_stb, m1_stb, m1_urgent, s_nak, s_stb, m0_nak, m1_nak, starve;
  logic [31:0] m0_addr, m1_addr, m0_dout, m1_dout, m0_din, m1_din;
  logic [31:0] s_addr, s_din, s_dout;
  logic [3:0]  m0_dm, m1_dm, s_dm;
  logic [1:0]  grant;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_dbus_scheduler dut (
    .clk(clk), .rst(rst),
    .m0_stb(m0_stb), .m0_addr(m0_addr), .m0_dm(m0_dm), .m0_dout(m0_dout),
    .m0_din(m0_din), .m0_nak(m0_nak),
    .m1_stb(m1_stb), .m1_addr(m1_addr), .m1_dm(m1_dm), .m1_dout(m1_dout),
    .m1_din(m1_din), .m1_nak(m1_nak), .m1_urgent(m1_urgent),
    .s_stb(s_stb), .s_addr(s_addr), .s_dm(s_dm), .s_din(s_din),
    .s_dout(s_dout), .s_nak(s_nak), .grant(grant), .starve(starve)
  );

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_stb = 0; m1_stb = 0; m1_urgent = 0; s_nak = 1; s_dout = '0;
    m0_addr = '0; m1_addr = '0; m0_dm = '0; m1_dm = '0; m0_dout = '0; m1_dout = '0;
  endtask

  task automatic apply_reset();
    rst = 1;
    idle_inputs();
    adv();
    adv();
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; m0_stb = 1; m1_stb = 1;
    adv();
    adv();
    @(negedge clk);
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b expected 00", grant); end
    checks++; if (s_stb !== 1'b0) begin errors++; $display("FAIL reset_s_stb: got %b expected 0", s_stb); end
    checks++; if ({m0_nak, m1_nak} !== 2'b11) begin errors++; $display("FAIL reset_nak: got %b expected 11", {m0_nak, m1_nak}); end
    checks++; if ((m0_din | m1_din) !== 32'h0) begin errors++; $display("FAIL reset_din: got %h/%h expected 0", m0_din, m1_din); end
    checks++; if (starve !== 1'b0) begin errors++; $display("FAIL reset_starve: got %b expected 0", starve); end
    rst = 0; m0_stb = 0; m1_stb = 0;
    adv();
  endtask

  task automatic test_m0_read();
    int nak_low = 0;
    m0_stb = 1; m0_addr = 32'h100; m0_dm = 4'b0000; s_nak = 1; s_dout = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL t1_arb_grant: got %b expected 00", grant); end
    if (!m0_nak) nak_low++;
    adv();
    @(negedge clk);
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL t1_grant: got %b expected 01", grant); end
    checks++; if (s_stb !== 1'b1 || s_addr !== 32'h100) begin errors++; $display("FAIL t1_slave_req: got stb=%b addr=%h expected 1/100", s_stb, s_addr); end
    if (!m0_nak) nak_low++;
    adv();
    @(negedge clk);
    if (!m0_nak) nak_low++;
    adv();
    s_nak = 0;
    @(negedge clk);
    checks++; if (m0_nak !== 1'b0 || m0_din !== 32'hDEADBEEF) begin errors++; $display("FAIL t1_accept: got nak=%b din=%h expected 0/deadbeef", m0_nak, m0_din); end
    if (!m0_nak) nak_low++;
    $display("t1: M0 read 0x100 accepted data=%h", m0_din);
    adv();
    m0_stb = 0; s_nak = 1;
    @(negedge clk);
    checks++; if (s_stb !== 1'b0 || grant !== 2'b01) begin errors++; $display("FAIL t1_release: got stb=%b grant=%b expected 0/01", s_stb, grant); end
    adv();
    @(negedge clk);
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL t1_idle: got %b expected 00", grant); end
    checks++; if (nak_low != 1) begin errors++; $display("FAIL t1_nak_low_cycles: got %0d expected 1", nak_low); end
    adv();
  endtask

  task automatic test_alternate();
    logic [1:0] exp_g [0:7];
    exp_g = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    apply_reset();
    m0_stb = 1; m1_stb = 1; s_nak = 0; m0_addr = 32'h200; m1_addr = 32'h300;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++; if (grant !== exp_g[i]) begin errors++; $display("FAIL t2_grant[%0d]: got %b expected %b", i, grant, exp_g[i]); end
      if (exp_g[i] == 2'b01) begin
        checks++; if ({m0_nak, m1_nak} !== 2'b01) begin errors++; $display("FAIL t2_m0_accept[%0d]: got naks %b expected 01", i, {m0_nak, m1_nak}); end
        $display("t2: cycle %0d M0 accept", i);
      end else if (exp_g[i] == 2'b10) begin
        checks++; if ({m0_nak, m1_nak} !== 2'b10) begin errors++; $display("FAIL t2_m1_accept[%0d]: got naks %b expected 10", i, {m0_nak, m1_nak}); end
        $display("t2: cycle %0d M1 accept", i);
      end
      adv();
    end
    m0_stb = 0; m1_stb = 0;
    adv();
    s_nak = 1;
  endtask

  task automatic test_burst();
    logic exp_acc [0:12];
    int k = 0;
    int accepted = 0;
    exp_acc = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    m1_stb = 1; s_nak = 0; m1_urgent = 0;
    for (int c = 0; c < 13; c++) begin
      m1_addr = 32'h4000 + 32'(4 * k);
      @(negedge clk);
      checks++; if ((m1_stb & ~m1_nak) !== exp_acc[c]) begin errors++; $display("FAIL t3_accept[%0d]: got %b expected %b", c, m1_stb & ~m1_nak, exp_acc[c]); end
      if (m1_stb && !m1_nak) begin
        accepted++;
        $display("t3: cycle %0d M1 accept #%0d addr=%h", c, accepted, s_addr);
      end
      if (exp_acc[c]) begin
        checks++; if (s_addr !== 32'h4000 + 32'(4 * k)) begin errors++; $display("FAIL t3_addr[%0d]: got %h expected %h", c, s_addr, 32'h4000 + 32'(4 * k)); end
        k++;
      end
      adv();
    end
    m1_stb = 0;
    @(negedge clk);
    checks++; if (s_stb !== 1'b0 || grant !== 2'b10) begin errors++; $display("FAIL t3_release: got stb=%b grant=%b expected 0/10", s_stb, grant); end
    adv();
    @(negedge clk);
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL t3_idle: got %b expected 00", grant); end
    checks++; if (accepted != 10) begin errors++; $display("FAIL t3_count: got %0d expected 10", accepted); end
    adv();
    s_nak = 1;
  endtask

  task automatic test_starve();
    logic [1:0] exp_g;
    logic       exp_s;
    apply_reset();
    m0_stb = 1; m0_addr = 32'h500; m1_stb = 1; m1_urgent = 1; m1_addr = 32'h5000; s_nak = 0;
    for (int c = 0; c < 18; c++) begin
      if (c == 17) m1_stb = 0;
      exp_g = (c == 0 || c == 5 || c == 10 || c == 15 || c == 17) ? 2'b00 : 2'b10;
      exp_s = (c >= 16);
      @(negedge clk);
      checks++; if (grant !== exp_g) begin errors++; $display("FAIL t4_grant[%0d]: got %b expected %b", c, grant, exp_g); end
      checks++; if (starve !== exp_s) begin errors++; $display("FAIL t4_starve[%0d]: got %b expected %b", c, starve, exp_s); end
      adv();
    end
    @(negedge clk);
    checks++; if (grant !== 2'b01 || m0_nak !== 1'b0) begin errors++; $display("FAIL t4_m0_win: got grant=%b nak=%b expected 01/0", grant, m0_nak); end
    $display("t4: M0 accept after starvation addr=%h", s_addr);
    adv();
    m0_stb = 0;
    @(negedge clk);
    checks++; if (starve !== 1'b0) begin errors++; $display("FAIL t4_starve_clear: got %b expected 0", starve); end
    adv();
    m1_urgent = 0; s_nak = 1;
  endtask

  task automatic test_reset_mid();
    m0_stb = 1; m0_addr = 32'h2000; m0_dm = 4'b0011; m0_dout = 32'h12345678; s_nak = 1;
    @(negedge clk);
    adv();
    @(negedge clk);
    checks++; if (s_stb !== 1'b1 || grant !== 2'b01) begin errors++; $display("FAIL t5_granted: got stb=%b grant=%b expected 1/01", s_stb, grant); end
    checks++; if (s_addr !== 32'h2000 || s_dm !== 4'b0011 || s_din !== 32'h12345678) begin errors++; $display("FAIL t5_write_mux: got %h/%b/%h expected 2000/0011/12345678", s_addr, s_dm, s_din); end
    adv();
    rst = 1;
    @(negedge clk);
    checks++; if (s_stb !== 1'b1) begin errors++; $display("FAIL t5_pre_edge: got stb=%b expected 1", s_stb); end
    adv();
    @(negedge clk);
    checks++; if (s_stb !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL t5_after_rst: got stb=%b grant=%b expected 0/00", s_stb, grant); end
    rst = 0; m0_stb = 0; s_nak = 0;
    for (int c = 0; c < 2; c++) begin
      adv();
      @(negedge clk);
      checks++; if (grant !== 2'b00 || s_stb !== 1'b0 || m0_nak !== 1'b1) begin errors++; $display("FAIL t5_no_phantom[%0d]: got grant=%b stb=%b nak=%b expected 00/0/1", c, grant, s_stb, m0_nak); end
    end
    adv();
    s_nak = 1; m0_dm = 4'b0000;
  endtask

  task automatic test_abort();
    m1_stb = 1; m1_addr = 32'h600; s_nak = 1;
    @(negedge clk);
    adv();
    m0_stb = 1; m0_addr = 32'h700;
    @(negedge clk);
    checks++; if (grant !== 2'b10 || s_stb !== 1'b1 || m0_nak !== 1'b1) begin errors++; $display("FAIL t6_m1_granted: got grant=%b stb=%b m0_nak=%b expected 10/1/1", grant, s_stb, m0_nak); end
    adv();
    m1_stb = 0;
    @(negedge clk);
    checks++; if (s_stb !== 1'b0 || grant !== 2'b10) begin errors++; $display("FAIL t6_abort: got stb=%b grant=%b expected 0/10", s_stb, grant); end
    adv();
    @(negedge clk);
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL t6_idle: got %b expected 00", grant); end
    adv();
    s_nak = 0;
    @(negedge clk);
    checks++; if (grant !== 2'b01 || s_addr !== 32'h700 || m0_nak !== 1'b0) begin errors++; $display("FAIL t6_m0_next: got grant=%b addr=%h nak=%b expected 01/700/0", grant, s_addr, m0_nak); end
    $display("t6: M0 accept after M1 abort addr=%h", s_addr);
    adv();
    m0_stb = 0; s_nak = 1;
    adv();
  endtask

  initial begin
    test_reset();
    test_m0_read();
    test_alternate();
    test_burst();
    test_starve();
    test_reset_mid();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
